ss_rvc_store_buf: RTL and testbench

- Store write buffer directly downstream of the core's Q103H data-memory write port.
- Captures each store (address, data) into a FIFO and drains it in order to the shared data-memory bus through a valid/ready handshake.
- Lets the core continue while the shared bus is busy; raises a stall to the core only when the FIFO is full.

---
 rtl/ss_rvc_store_buf_if.sv | 29 ++
 rtl/ss_rvc_store_buf.sv | 84 ++++++++
 tb/tb_ss_rvc_store_buf.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ss_rvc_store_buf_if.sv
// Core-side store port and shared data-memory bus handshake for ss_rvc_store_buf.
// The slave modport is the buffer; the master modport is the core/bus side driving it.
interface ss_rvc_store_buf_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    logic [XLEN-1:0]              AddressDmQ103H;
    logic [XLEN-1:0]              WrDataDmQ103H;
    logic                         WrEnDmQ103H;
    logic                         StoreStallQ103H;
    logic                         BusValidQnnnH;
    logic [XLEN-1:0]              BusAddrQnnnH;
    logic [XLEN-1:0]              BusDataQnnnH;
    logic                         BusReadyQnnnH;
    logic                         BufEmptyQnnnH;
    logic [$clog2(DEPTH+1)-1:0]   BufCountQnnnH;

    modport slave (
        input  AddressDmQ103H, WrDataDmQ103H, WrEnDmQ103H, BusReadyQnnnH,
        output StoreStallQ103H, BusValidQnnnH, BusAddrQnnnH, BusDataQnnnH,
               BufEmptyQnnnH, BufCountQnnnH
    );

    modport master (
        output AddressDmQ103H, WrDataDmQ103H, WrEnDmQ103H, BusReadyQnnnH,
        input  StoreStallQ103H, BusValidQnnnH, BusAddrQnnnH, BusDataQnnnH,
               BufEmptyQnnnH, BufCountQnnnH
    );
endinterface

// File: rtl/ss_rvc_store_buf.sv
// In-order store write buffer between the core store port and the shared data-memory bus.
// Optional SS_RVC_STORE_MERGE_EN: a store to the newest entry's address overwrites it in place.
module ss_rvc_store_buf #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                 QClk,
    input  logic                 RstQnnnH,
    ss_rvc_store_buf_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_addr [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_merge;
    logic w_stall;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & bus.BusReadyQnnnH;

`ifdef SS_RVC_STORE_MERGE_EN
    logic [PW-1:0] w_newest;
    logic          w_addr_hit;

    assign w_newest   = r_wptr - PW'(1);
    assign w_addr_hit = bus.WrEnDmQ103H & ~w_empty &
                        (r_addr[w_newest] == bus.AddressDmQ103H);
    // The newest entry is the head only when count==1; a pop then would consume it.
    assign w_merge    = w_addr_hit & ~(w_pop & (r_count == CW'(1)));
    // When full the newest entry is never the head (DEPTH>=2), so the stall needs no bus-ready term.
    assign w_stall    = w_full & ~w_addr_hit;
`else
    assign w_merge    = 1'b0;
    assign w_stall    = w_full;
`endif

    assign w_push = bus.WrEnDmQ103H & ~w_stall & ~w_merge;

    always_ff @(posedge QClk) begin
        if (w_push) begin
            r_addr[r_wptr] <= bus.AddressDmQ103H;
            r_data[r_wptr] <= bus.WrDataDmQ103H;
        end
`ifdef SS_RVC_STORE_MERGE_EN
        if (w_merge) begin
            r_data[w_newest] <= bus.WrDataDmQ103H;
        end
`endif
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset, so the head is gated to zero while empty.
    assign bus.StoreStallQ103H = w_stall;
    assign bus.BusValidQnnnH   = ~w_empty;
    assign bus.BusAddrQnnnH    = w_empty ? '0 : r_addr[r_rptr];
    assign bus.BusDataQnnnH    = w_empty ? '0 : r_data[r_rptr];
    assign bus.BufEmptyQnnnH   = w_empty;
    assign bus.BufCountQnnnH   = r_count;
endmodule

// File: tb/tb_ss_rvc_store_buf.sv
// Self-checking bench for ss_rvc_store_buf: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_ss_rvc_store_buf;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic QClk     = 1'b0;
    logic RstQnnnH = 1'b1;
    always #5 QClk = ~QClk;

    ss_rvc_store_buf_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus_if ();

    ss_rvc_store_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .QClk     (QClk),
        .RstQnnnH (RstQnnnH),
        .bus      (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the buffer contents as an ordered list of (addr, data).
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] pop_log[$];
    logic        m_accept = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_hit();
`ifdef SS_RVC_STORE_MERGE_EN
        return bus_if.WrEnDmQ103H && qa.size() != 0 && qa[qa.size()-1] == bus_if.AddressDmQ103H;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_stall();
        return (qa.size() == DEPTH) && !m_hit();
    endfunction

    initial begin
        forever begin
            @(posedge QClk or posedge RstQnnnH);
            if (RstQnnnH) begin
                qa.delete();
                qd.delete();
                m_accept = 1'b0;
            end else begin
                logic pop, merge, push, stall;
                pop   = qa.size() != 0 && bus_if.BusReadyQnnnH;
                stall = m_stall();
                merge = m_hit() && !(pop && qa.size() == 1);
                push  = bus_if.WrEnDmQ103H && !stall && !merge;
                m_accept = bus_if.WrEnDmQ103H && !stall;
                if (merge) qd[qd.size()-1] = bus_if.WrDataDmQ103H;
                if (pop) begin
                    pop_log.push_back(qa[0]);
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                if (push) begin
                    qa.push_back(bus_if.AddressDmQ103H);
                    qd.push_back(bus_if.WrDataDmQ103H);
                end
            end
        end
    end

    // Per-cycle compare of every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge QClk);
            if (!RstQnnnH) begin
                chk("cmp_stall", 32'(bus_if.StoreStallQ103H), 32'(m_stall()));
                chk("cmp_valid", 32'(bus_if.BusValidQnnnH), 32'(qa.size() != 0));
                chk("cmp_addr",  bus_if.BusAddrQnnnH, qa.size() != 0 ? qa[0] : 32'h0);
                chk("cmp_data",  bus_if.BusDataQnnnH, qd.size() != 0 ? qd[0] : 32'h0);
                chk("cmp_empty", 32'(bus_if.BufEmptyQnnnH), 32'(qa.size() == 0));
                chk("cmp_count", 32'(bus_if.BufCountQnnnH), qa.size());
            end
        end
    end

    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        bus_if.WrEnDmQ103H    = w;
        bus_if.AddressDmQ103H = a;
        bus_if.WrDataDmQ103H  = d;
        bus_if.BusReadyQnnnH  = r;
        @(posedge QClk);
        #2;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (qa.size() != 0 && n < 50) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        chk({nm, "_drained"}, 32'(bus_if.BufEmptyQnnnH), 32'h1);
    endtask

    initial begin
        logic        pw;
        logic [31:0] pa, pd;
        logic [31:0] exp_fill [5];
        logic        r;
        int          i, n;

        bus_if.WrEnDmQ103H    = 1'b0;
        bus_if.AddressDmQ103H = '0;
        bus_if.WrDataDmQ103H  = '0;
        bus_if.BusReadyQnnnH  = 1'b0;

        #3;
        chk("rst_valid", 32'(bus_if.BusValidQnnnH), 32'h0);
        chk("rst_empty", 32'(bus_if.BufEmptyQnnnH), 32'h1);
        chk("rst_count", 32'(bus_if.BufCountQnnnH), 32'h0);
        chk("rst_stall", 32'(bus_if.StoreStallQ103H), 32'h0);
        #9 RstQnnnH = 1'b0;

        // Single store, ready high: visible the cycle after the push edge, gone after the pop edge.
        cyc(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        chk("single_valid", 32'(bus_if.BusValidQnnnH), 32'h1);
        chk("single_addr",  bus_if.BusAddrQnnnH, 32'h100);
        chk("single_data",  bus_if.BusDataQnnnH, 32'hDEADBEEF);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("single_empty", 32'(bus_if.BufEmptyQnnnH), 32'h1);
        chk("single_vld0",  32'(bus_if.BusValidQnnnH), 32'h0);

        // Fill with ready low, hold the fifth store through the stall.
        pop_log.delete();
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1'b0);
        chk("fill_stall", 32'(bus_if.StoreStallQ103H), 32'h1);
        chk("fill_count", 32'(bus_if.BufCountQnnnH), 32'h4);
        cyc(1'b1, 32'h10, 32'h1004, 1'b0);
        chk("fill_hold_count", 32'(bus_if.BufCountQnnnH), 32'h4);
        cyc(1'b1, 32'h10, 32'h1004, 1'b1);
        chk("full_pop_count", 32'(bus_if.BufCountQnnnH), 32'h3);
        chk("full_pop_stall", 32'(bus_if.StoreStallQ103H), 32'h0);
        chk("full_pop_addr",  bus_if.BusAddrQnnnH, 32'h4);
        cyc(1'b1, 32'h10, 32'h1004, 1'b1);
        chk("fill_pp_count", 32'(bus_if.BufCountQnnnH), 32'h3);
        drain("fill");
        exp_fill = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        chk("fill_npop", pop_log.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            chk("fill_order", k < pop_log.size() ? pop_log[k] : 32'hFFFFFFFF, exp_fill[k]);

        // Push and pop together at count 2.
        cyc(1'b1, 32'h30, 32'h1, 1'b0);
        cyc(1'b1, 32'h34, 32'h2, 1'b0);
        cyc(1'b1, 32'h38, 32'h3, 1'b1);
        chk("simul_count", 32'(bus_if.BufCountQnnnH), 32'h2);
        chk("simul_addr",  bus_if.BusAddrQnnnH, 32'h34);
        drain("simul");

        // Same-address pair: merged in place only when the merge option is built in.
        cyc(1'b1, 32'h20, 32'h1, 1'b0);
        cyc(1'b1, 32'h20, 32'h2, 1'b0);
`ifdef SS_RVC_STORE_MERGE_EN
        chk("merge_count", 32'(bus_if.BufCountQnnnH), 32'h1);
        chk("merge_data",  bus_if.BusDataQnnnH, 32'h2);
`else
        chk("merge_count", 32'(bus_if.BufCountQnnnH), 32'h2);
        chk("merge_data",  bus_if.BusDataQnnnH, 32'h1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("merge_data2", bus_if.BusDataQnnnH, 32'h2);
`endif
        drain("merge");

        // Ten back-to-back stores with ready toggling: pointers wrap twice.
        pop_log.delete();
        i = 0;
        n = 0;
        r = 1'b1;
        while (i < 10 && n < 100) begin
            cyc(1'b1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), r);
            if (m_accept) i++;
            r = ~r;
            n++;
        end
        chk("wrap_accepted", i, 32'd10);
        drain("wrap");
        chk("wrap_npop", pop_log.size(), 32'd10);
        for (int k = 0; k < 10; k++)
            chk("wrap_order", k < pop_log.size() ? pop_log[k] : 32'hFFFFFFFF, 32'h200 + 32'(4 * k));

        // Randomized traffic; the core holds a stalled store until accepted.
        pw = 1'b0;
        pa = '0;
        pd = '0;
        for (int k = 0; k < 1500; k++) begin
            if (!(pw && !m_accept)) begin
                pw = ($urandom_range(0, 9) < 7);
                pa = 32'($urandom_range(0, 3)) << 2;
                pd = $urandom;
            end
            cyc(pw, pa, pd, 1'($urandom_range(0, 1)));
        end
        drain("rand");

        // Asynchronous reset with three entries held.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h300 + 32'(4 * k), 32'h77 + 32'(k), 1'b0);
        chk("prerst_count", 32'(bus_if.BufCountQnnnH), 32'h3);
        #1 RstQnnnH = 1'b1;
        #1;
        chk("arst_valid", 32'(bus_if.BusValidQnnnH), 32'h0);
        chk("arst_addr",  bus_if.BusAddrQnnnH, 32'h0);
        chk("arst_data",  bus_if.BusDataQnnnH, 32'h0);
        chk("arst_empty", 32'(bus_if.BufEmptyQnnnH), 32'h1);
        chk("arst_count", 32'(bus_if.BufCountQnnnH), 32'h0);
        chk("arst_stall", 32'(bus_if.StoreStallQ103H), 32'h0);
        bus_if.WrEnDmQ103H = 1'b0;
        @(negedge QClk);
        #2 RstQnnnH = 1'b0;
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("post_rst_empty", 32'(bus_if.BufEmptyQnnnH), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
